// File: rtl/mem_access_stage.sv
// MEM stage: one req/ack data-memory transaction per load/store, lane-aligned load result; min 3 cycles (2 stall), TIMEOUT bound.
// Backpressure: mem_stall holds upstream until DONE; optional MEM_MISALIGN_TRAP_EN traps misaligned half/word without a bus request.
module mem_access_stage #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_MemRead,
  input  logic        m_MemWrite,
  input  logic [2:0]  m_Mmask,
  input  logic [31:0] m_alu_out,
  input  logic [31:0] m_mem_data,
  output logic        mem_stall,
  output logic [31:0] ld_data,
  output logic        bus_err,
  output logic        misalign,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [3:0]  d_be,
  output logic [31:0] d_wdata,
  input  logic        d_ack,
  input  logic [31:0] d_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  mask_q;
  logic [1:0]  off_q;

  logic        access;
  logic        is_byte, is_half;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;

  assign access    = m_MemRead | m_MemWrite;
  assign mem_stall = (state == BUSY) | ((state == IDLE) & access);

  always_comb begin
    is_byte   = (m_Mmask[1:0] == 2'b00);
    is_half   = (m_Mmask[1:0] == 2'b01);
    be_nxt    = 4'b1111;
    wdata_nxt = m_mem_data;
    if (is_byte) begin
      be_nxt    = 4'b0001 << m_alu_out[1:0];
      wdata_nxt = {4{m_mem_data[7:0]}};
    end else if (is_half) begin
      be_nxt    = 4'b0011 << {m_alu_out[1], 1'b0};
      wdata_nxt = {2{m_mem_data[15:0]}};
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_nxt;
  logic mis_q;
  assign mis_nxt  = (is_half & m_alu_out[0]) |
                    (!is_byte && !is_half && (m_alu_out[1:0] != 2'b00));
  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

  // Picks the addressed lane out of the returned word and extends it by size.
  function automatic logic [31:0] extend(input logic [2:0] mask, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] sh;
    logic [15:0] h;
    sh = w >> {off, 3'b000};
    h  = off[1] ? w[31:16] : w[15:0];
    case (mask[1:0])
      2'b00:   extend = mask[2] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extend = mask[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: extend = w;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mask_q  <= '0;
      off_q   <= '0;
      ld_data <= '0;
      bus_err <= 1'b0;
      d_req   <= 1'b0;
      d_we    <= 1'b0;
      d_addr  <= '0;
      d_be    <= '0;
      d_wdata <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      ld_data <= '0;
      bus_err <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (access) begin
            d_we    <= m_MemWrite;
            d_addr  <= {m_alu_out[31:2], 2'b00};
            d_be    <= be_nxt;
            d_wdata <= wdata_nxt;
            mask_q  <= m_Mmask;
            off_q   <= m_alu_out[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
            if (mis_nxt) begin
              state <= DONE;
              mis_q <= 1'b1;
            end else begin
              state <= BUSY;
              d_req <= 1'b1;
            end
`else
            state <= BUSY;
            d_req <= 1'b1;
`endif
          end
        end
        BUSY: begin
          // An ack on the final allowed cycle still completes normally.
          if (d_ack) begin
            state <= DONE;
            d_req <= 1'b0;
            if (!d_we) ld_data <= extend(mask_q, off_q, d_rdata);
          end else if (cnt == TO_LAST) begin
            state   <= DONE;
            d_req   <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
